// File: rtl/pipe_add_pkg.sv
// Shared defaults for the segmented pipelined adder/subtractor.
// Holds default geometry and the stage-0 carry-in rule.
package pipe_add_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  // Subtract forces carry-in to 1 (A + ~B + 1); add passes cin through.
  function automatic logic first_cin(
    input logic sub,
    input logic cin
  );
    return sub | cin;
  endfunction

endpackage

// File: rtl/pipe_add_add_seg.sv
// Combinational SEG-bit ripple segment adder for pipe_add.
// c_msb_in is the carry entering the segment MSB (signed overflow).
module add_seg
  import pipe_add_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb_in
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  // sum bit = a ^ b ^ carry-in, so the MSB carry-in falls out for free.
  assign c_msb_in = sum[SEG-1] ^ a[SEG-1] ^ b[SEG-1];

endmodule

// File: rtl/pipe_add.sv
// Pipelined add/sub: WIDTH split into STAGES segments, carry registered.
// Optional signed-overflow output enabled by PIPE_ADD_OVF_EN.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PIPE_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;

  logic [STAGES:0]   adv;
  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  bx;

  assign bx = in_sub ? ~in_b : in_b;

  // An empty stage always advances, so bubbles collapse under stall.
  always_comb begin
    adv[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  assign in_ready = adv[0] && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int FW = WIDTH - k * SEG;

    logic [FW-1:0]        fa;
    logic [FW-1:0]        fb;
    logic [SEG-1:0]       ss;
    logic [(k+1)*SEG-1:0] sum;
    logic [(k+1)*SEG-1:0] sum_d;
    logic                 ci;
    logic                 co;
    logic                 cm;
    logic                 c;
    logic                 vin;
    logic                 unused_cm;

    assign unused_cm = cm;

    if (k == 0) begin : g_feed
      assign fa    = in_a;
      assign fb    = bx;
      assign ci    = first_cin(in_sub, in_cin);
      assign vin   = in_valid;
      assign sum_d = ss;
    end else begin : g_feed
      assign fa    = g_st[k-1].g_op.a;
      assign fb    = g_st[k-1].g_op.b;
      assign ci    = g_st[k-1].c;
      assign vin   = v[k-1];
      assign sum_d = {ss, g_st[k-1].sum};
    end

    add_seg #(
      .SEG(SEG)
    ) u_seg (
      .a        (fa[SEG-1:0]),
      .b        (fb[SEG-1:0]),
      .cin      (ci),
      .sum      (ss),
      .cout     (co),
      .c_msb_in (cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v[k] <= 1'b0;
        sum  <= '0;
        c    <= 1'b0;
      end else if (adv[k]) begin
        v[k] <= vin;
        sum  <= sum_d;
        c    <= co;
      end
    end

    // Operand skew: carry forward only the segments not yet consumed.
    if (FW > SEG) begin : g_op
      logic [FW-SEG-1:0] a;
      logic [FW-SEG-1:0] b;

      always_ff @(posedge clk) begin
        if (adv[k]) begin
          a <= fa[FW-1:SEG];
          b <= fb[FW-1:SEG];
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_sum   = g_st[STAGES-1].sum;
  assign out_cout  = g_st[STAGES-1].c;

`ifdef PIPE_ADD_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ovf <= 1'b0;
    end else if (adv[STAGES-1]) begin
      out_ovf <= g_st[STAGES-1].cm ^ g_st[STAGES-1].co;
    end
  end
`endif

endmodule
